// File: rtl/c17_resp_checker.sv
// c17_resp_checker: realigns applied c17 vectors with the DUT responses across the DUT pipeline,
// checks them against a built-in golden c17 model and accumulates errors plus a MISR signature.
module c17_resp_checker #(
  parameter int               LATENCY     = 1,
  parameter int               NUM_VECTORS = 32,
  parameter int               ERR_W       = 8,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(16'h1021)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       vec_in,
  input  logic             vec_valid,
  input  logic             dut_n22,
  input  logic             dut_n23,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       first_fail_vec,
  output logic             first_fail_vld,
  output logic [7:0]       check_count,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Nine-bit internal count so that NUM_VECTORS=256 is still reachable.
  localparam logic [8:0] LAST_CNT = 9'(NUM_VECTORS - 1);

  function automatic logic [1:0] golden(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1  = v[0];
    n2  = v[1];
    n3  = v[2];
    n6  = v[3];
    n7  = v[4];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [1:0]       d);
    logic [SIG_W-1:0] nxt;
    nxt = {sig[SIG_W-2:0], 1'b0};
    if (sig[SIG_W-1]) begin
      nxt = nxt ^ POLY;
    end else begin
      nxt = nxt;
    end
    return nxt ^ {{(SIG_W-2){1'b0}}, d};
  endfunction

  state_e           state_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [4:0]       ffv_q;
  logic             ffvld_q;

  logic             run_s, chk_s, mism_s, start_ok_s, last_s;
  logic             del_vld_s;
  logic [4:0]       del_vec_s;
  logic [1:0]       resp_s;

  if (LATENCY == 0) begin : g_nodelay
    assign del_vld_s = vec_valid;
    assign del_vec_s = vec_in;
  end else begin : g_delay
    logic [LATENCY-1:0] vld_q;
    logic [4:0]         vec_q [LATENCY];
    logic               push_s, flush_s;

    assign push_s  = run_s && vec_valid;
    assign flush_s = abort || start_ok_s || last_s;

    // Shift register carrying applied vectors until their responses emerge from the DUT.
    always_ff @(posedge clk) begin
      if (r || flush_s) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          vec_q[i] <= 5'd0;
        end
      end else begin
        vld_q[0] <= push_s;
        vec_q[0] <= push_s ? vec_in : 5'd0;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          vec_q[i] <= vec_q[i-1];
        end
      end
    end

    assign del_vld_s = vld_q[LATENCY-1];
    assign del_vec_s = vec_q[LATENCY-1];
  end

  // Check-event decode and next values of the result registers.
  always_comb begin
    run_s      = (state_q == S_RUN);
    chk_s      = run_s && del_vld_s;
    resp_s     = {dut_n23, dut_n22};
    mism_s     = chk_s && (resp_s != golden(del_vec_s));
    start_ok_s = start && !abort && !run_s;
    last_s     = chk_s && (cnt_q == LAST_CNT);
    if (mism_s && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
    cnt_d = cnt_q + 9'd1;
    sig_d = misr_step(sig_q, resp_s);
  end

  // Run-control FSM with registered status and result outputs; abort outranks start.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= 9'd0;
      sig_q   <= '0;
      ffv_q   <= 5'd0;
      ffvld_q <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (start_ok_s) begin
      state_q <= S_RUN;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= 9'd0;
      sig_q   <= '0;
      ffv_q   <= 5'd0;
      ffvld_q <= 1'b0;
    end else if (chk_s) begin
      err_q <= err_d;
      cnt_q <= cnt_d;
      sig_q <= sig_d;
      if (mism_s && !ffvld_q) begin
        ffv_q   <= del_vec_s;
        ffvld_q <= 1'b1;
      end
      if (last_s) begin
        state_q <= S_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= (err_d == '0);
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffvld_q;
  assign check_count    = cnt_q[7:0];
  assign signature      = sig_q;

endmodule

// File: tb/tb_c17_resp_checker.sv
// Self-checking bench: two checker instances (LATENCY=1/ERR_W=8 and LATENCY=2/ERR_W=2) against a
// cycle-history reference model, plus literal expectations for the directed scenarios.
module tb_c17_resp_checker;

  localparam int HN = 8192;
  localparam int NV = 32;

  logic       clk = 1'b0;
  logic       r = 1'b1, start = 1'b0, abort = 1'b0, vec_valid = 1'b0;
  logic [4:0] vec_in = 5'd0;
  logic [1:0] rsp_drv [2];

  logic       a_busy, a_done, a_pass, a_ffvld, b_busy, b_done, b_pass, b_ffvld;
  logic [7:0] a_err, a_cnt, b_cnt;
  logic [1:0] b_err;
  logic [4:0] a_ffv, b_ffv;
  logic [15:0] a_sig, b_sig;

  int checks = 0, errors = 0, cyc = 0, fault = 0;
  bit chk_en = 1'b0;
  int LAT [2] = '{1, 2};
  int ERRMAX [2] = '{255, 3};

  logic [4:0] raw_vec [HN];
  bit         hist_vld [2][HN];
  int         m_state [2], m_err [2], m_cnt [2], m_ffv [2], m_ffvld [2], m_sig [2], m_rb [2];

  always #5 clk = ~clk;

  c17_resp_checker #(.LATENCY(1), .NUM_VECTORS(NV), .ERR_W(8)) u_a (
    .clk(clk), .r(r), .start(start), .abort(abort), .vec_in(vec_in), .vec_valid(vec_valid),
    .dut_n22(rsp_drv[0][0]), .dut_n23(rsp_drv[0][1]), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail_vec(a_ffv), .first_fail_vld(a_ffvld),
    .check_count(a_cnt), .signature(a_sig));

  c17_resp_checker #(.LATENCY(2), .NUM_VECTORS(NV), .ERR_W(2)) u_b (
    .clk(clk), .r(r), .start(start), .abort(abort), .vec_in(vec_in), .vec_valid(vec_valid),
    .dut_n22(rsp_drv[1][0]), .dut_n23(rsp_drv[1][1]), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail_vec(b_ffv), .first_fail_vld(b_ffvld),
    .check_count(b_cnt), .signature(b_sig));

  // c17 truth in sum-of-products form: {exp23, exp22}
  function automatic logic [1:0] gold(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, both36;
    {n7, n6, n3, n2, n1} = v;
    both36 = n3 & n6;
    return {(n2 | n7) & ~both36, (n1 & n3) | (n2 & ~both36)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int c, j, s;
    logic [1:0] rsp;
    c = cyc % HN;
    if (r) begin
      m_state[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_ffv[k] = 0; m_ffvld[k] = 0;
      m_sig[k] = 0; m_rb[k] = 0; hist_vld[k][c] = 1'b0;
      return;
    end
    hist_vld[k][c] = vec_valid && (m_state[k] == 1);
    if (abort) begin
      m_state[k] = 0;
    end else if (start && m_state[k] != 1) begin
      m_state[k] = 1; m_err[k] = 0; m_cnt[k] = 0; m_ffv[k] = 0; m_ffvld[k] = 0;
      m_sig[k] = 0; m_rb[k] = cyc + 1;
    end else if (m_state[k] == 1) begin
      j = cyc - LAT[k];
      if (j >= m_rb[k] && hist_vld[k][j % HN]) begin
        rsp = rsp_drv[k];
        m_cnt[k]++;
        s = m_sig[k];
        m_sig[k] = (((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 32'h0)) ^ int'(rsp);
        if (rsp != gold(raw_vec[j % HN])) begin
          if (m_err[k] < ERRMAX[k]) m_err[k]++;
          if (m_ffvld[k] == 0) begin
            m_ffvld[k] = 1;
            m_ffv[k] = int'(raw_vec[j % HN]);
          end
        end
        if (m_cnt[k] == NV) m_state[k] = 2;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  // Single compare process: every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", a_busy, m_state[0] == 1);
      chk("a_done", a_done, m_state[0] == 2);
      chk("a_pass", a_pass, m_state[0] == 2 && m_err[0] == 0);
      chk("a_err", a_err, m_err[0]);
      chk("a_cnt", a_cnt, m_cnt[0]);
      chk("a_ffvld", a_ffvld, m_ffvld[0]);
      chk("a_ffv", a_ffv, m_ffv[0]);
      chk("a_sig", a_sig, m_sig[0]);
      chk("b_busy", b_busy, m_state[1] == 1);
      chk("b_done", b_done, m_state[1] == 2);
      chk("b_pass", b_pass, m_state[1] == 2 && m_err[1] == 0);
      chk("b_err", b_err, m_err[1]);
      chk("b_cnt", b_cnt, m_cnt[1]);
      chk("b_ffvld", b_ffvld, m_ffvld[1]);
      chk("b_ffv", b_ffv, m_ffv[1]);
      chk("b_sig", b_sig, m_sig[1]);
    end
  end

  // One clock of stimulus; DUT responses follow the vector applied LAT cycles earlier.
  task automatic tick(input logic [4:0] v, input logic vld, input logic st, input logic ab,
                      input logic rr);
    logic [4:0] src;
    logic [1:0] g;
    @(negedge clk);
    vec_in = v; vec_valid = vld; start = st; abort = ab; r = rr;
    raw_vec[cyc % HN] = v;
    for (int k = 0; k < 2; k++) begin
      src = (cyc >= LAT[k]) ? raw_vec[(cyc - LAT[k]) % HN] : 5'd0;
      g = gold(src);
      if (fault == 1) g[0] = 1'b0;
      else if (fault == 2 && $urandom_range(0, 7) == 0) g = g ^ 2'($urandom_range(1, 3));
      rsp_drv[k] = g;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(a_done && b_done) && n < 100) begin
      idle(1);
      n++;
    end
    chk("done_timeout", a_done && b_done, 1);
  endtask

  initial begin
    rsp_drv[0] = 2'b00;
    rsp_drv[1] = 2'b00;
    tick(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    tick(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("rst_busy", a_busy, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_sig", a_sig, 0);

    // Back-to-back vectors 0..31 with a correct DUT
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int v = 0; v < 32; v++) tick(5'(v), 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t1_pass", a_pass, 1);
    chk("t1_err", a_err, 0);
    chk("t1_cnt", a_cnt, 32);
    chk("t1_b_cnt", b_cnt, 32);

    // Vectors 31 and 0 first (expected responses 01 and 00), then random
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick(5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t2_pass", a_pass, 1);
    chk("t2_b_pass", b_pass, 1);

    // N22 stuck-at-0: 18 of 32 vectors expect N22=1, first is vector 2
    fault = 1;
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int v = 0; v < 32; v++) tick(5'(v), 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done();
    fault = 0;
    chk("t3_err", a_err, 18);
    chk("t3_ffv", a_ffv, 2);
    chk("t3_ffvld", a_ffvld, 1);
    chk("t3_pass", a_pass, 0);
    chk("t3_b_err_sat", b_err, 3);
    chk("t3_b_ffv", b_ffv, 2);

    // Gaps of three idle cycles between vectors
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick(5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
    end
    wait_done();
    chk("t4_pass", a_pass, 1);
    chk("t4_b_pass", b_pass, 1);
    chk("t4_b_cnt", b_cnt, 32);

    // Abort after ten checks, then restart
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("t5_cnt_pre", a_cnt, 10);
    tick(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("t5_busy", a_busy, 0);
    chk("t5_done", a_done, 0);
    chk("t5_cnt", a_cnt, 10);
    tick(5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t5_cnt_hold", b_cnt, 10);
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t5_cnt_clr", a_cnt, 0);
    chk("t5_busy_run", a_busy, 1);

    // Randomised traffic: gaps, stray starts/aborts, response faults, occasional reset
    fault = 2;
    for (int i = 0; i < 2500; i++) begin
      tick(5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 599) == 0));
    end
    fault = 0;

    // Reset in the middle of a run
    tick(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(5'(i + 3), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t6_busy", a_busy, 0);
    chk("t6_cnt", a_cnt, 0);
    chk("t6_sig", a_sig, 0);
    chk("t6_b_cnt", b_cnt, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
